l2_arbiter: RTL and testbench
=============================

# l2_arbiter

Two-port request arbiter between the split L1 caches (I-cache, D-cache) and the unified 4-way L2. It accepts line-sized (256-bit) miss and write-back requests from both L1s, grants one at a time, and presents a single registered request to the L2 through its mem_read/mem_write/mem_address/mem_wdata interface. It then routes the L2 response back to the granted requester. Arbitration is round-robin by default, with a fixed-priority option.

## Interface
- FAIR, 1: 1 = round-robin on simultaneous requests; 0 = D-cache always wins.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_read  in  1  I-cache line-fill request; held until i_resp.
- i_address  in  32 (rv32i_word)  I-cache line address (bits 4:0 ignored).
- i_rdata  out  256  fill data to I-cache.
- i_resp  out  1  one-cycle completion pulse to I-cache.
- d_read  in  1  D-cache line-fill request; held until d_resp.
- d_write  in  1  D-cache write-back request; held until d_resp.
- d_address  in  32  D-cache line address.
- d_wdata  in  256  D-cache write-back line.
- d_rdata  out  256  fill data to D-cache.
- d_resp  out  1  one-cycle completion pulse to D-cache.
- mem_read  out  1  request to L2, read.
- mem_write  out  1  request to L2, write.
- mem_address  out  32  registered address to L2, bits 4:0 forced to 0.
- mem_wdata  out  256  registered write line to L2.
- mem_rdata  in  256  L2 read line.
- mem_resp  in  1  L2 completion pulse.

## Operation
- States: IDLE, SERVE_I, SERVE_D, RELEASE.
- IDLE:
  - No request: stay.
  - Only I requests: go to SERVE_I.
  - Only D requests (read or write): go to SERVE_D.
  - Both request, FAIR=1: grant the side not granted last (last_grant register; reset value = D, so I wins first tie).
  - Both request, FAIR=0: D wins.
- On the grant edge, latch into the request registers: address (low 5 bits zeroed), wdata, op. op is read for I. For D, op is write if d_write, else read.
- d_read and d_write high together is illegal. The write wins, and the simulation assertion fires.
- SERVE_x:
  - mem_read/mem_write are driven from the latched op and held constant until mem_resp.
  - Requester-side input changes are ignored.
  - On mem_resp: pulse x_resp combinationally in the same cycle, drive x_rdata = mem_rdata, update last_grant, go to RELEASE.
- RELEASE:
  - Exactly one cycle.
  - mem_read/mem_write = 0, no arbitration.
  - Gives the L1 controller one edge to drop its request, which prevents a duplicate grant.
  - Then go to IDLE.
- i_rdata and d_rdata both carry mem_rdata continuously. Only resp is steered.
- mem_resp in IDLE or RELEASE is ignored: no resp pulse, no state change.

## Timing
- Reset values:
  - state = IDLE, last_grant = D.
  - mem_read = mem_write = 0.
  - mem_address = 0, mem_wdata = 0.
  - i_resp = d_resp = 0.
- Grant latency: request high in IDLE at edge N, so mem_read/mem_write are high in cycle N+1. Minimum 1 cycle.
- Response latency: x_resp is high in the same cycle as mem_resp (0 added cycles).
- Turnaround: mem_resp in cycle M gives RELEASE in M+1 and IDLE in M+2. The earliest next L2 request is cycle M+3, giving 2 dead cycles between back-to-back transactions.
- rst asserted mid-transaction:
  - Next edge returns to IDLE with all outputs at reset values.
  - Any pending L2 response is dropped and no resp is issued.
  - Requesters retry from scratch.
- mem_read/mem_write never both high. Neither is high in IDLE or RELEASE.

## Structure
- The arb_state_t enum (IDLE, SERVE_I, SERVE_D, RELEASE) and the grant_t enum (GRANT_I, GRANT_D) go in rv32i_types alongside the existing types.
- Line width 256 and offset width 5 become package localparams shared with the L2.
- Single module: FSM plus a request register bank. No sub-module; the arbitration decision is a small always_comb.

## Test plan
- Single I miss: i_read=1, i_address=0x0000_1234. Required: mem_read=1 with mem_address=0x0000_1220 one cycle later. L2 mem_resp with rdata=0xAA..AA. Required: i_resp pulses that cycle with i_rdata=0xAA..AA, and d_resp stays 0.
- Simultaneous requests, FAIR=1, out of reset: i_read and d_read at same edge. Required: I served first, then D after RELEASE+IDLE. Repeat the tie: D served first.
- Simultaneous requests, FAIR=0: ties always grant D. Three consecutive ties: D served all three times, I only after D drops its request.
- D write-back: d_write=1, d_address=0x8000_0040, d_wdata=0x5555..55. Required: mem_write=1, mem_address=0x8000_0040, mem_wdata=0x5555..55, mem_read=0. Changing d_wdata mid-transaction leaves mem_wdata unchanged.
- Spurious/late response: mem_resp pulsed in IDLE, then in RELEASE. Required: no i_resp/d_resp and no state change.
- Reset mid-service: rst during SERVE_D before mem_resp. Required: next cycle mem_read=mem_write=0, state IDLE. A mem_resp arriving afterward produces no d_resp.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I / memory-hierarchy types.
//   rv32i_word  : 32-bit address/data word
//   LINE_W      : cache line width in bits, shared by the L1s, arbiter and L2
//   OFFSET_W    : byte-offset bits inside a line
//   arb_state_t : L2 arbiter FSM states
//   grant_t     : which L1 currently owns (or last owned) the L2 port
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  localparam int unsigned LINE_W   = 256;
  localparam int unsigned OFFSET_W = 5;

  typedef logic [LINE_W-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  // Clear the byte-offset bits so the L2 always sees a line-aligned address.
  function automatic rv32i_word line_align(input rv32i_word addr);
    return {addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/l2_arbiter.sv
// l2_arbiter: arbitrates line-fill / write-back requests from the I-cache
// and D-cache onto a single registered L2 request port, then steers the
// L2 completion pulse back to whichever L1 was granted.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no transaction; arbitrate among pending requests each edge
// SERVE_I | I-cache line fill outstanding at the L2
// SERVE_D | D-cache fill or write-back outstanding at the L2
// RELEASE | one dead cycle so the served L1 can drop its request
//
// Parameters:
//   FAIR        1 = round-robin on ties, 0 = D-cache always wins ties
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   i_*         I-cache request (read only) / fill data / completion
//   d_*         D-cache request (read or write) / fill data / completion
//   mem_*       registered request to L2, L2 read data and completion
module l2_arbiter
  import rv32i_types::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  rv32i_word         i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  rv32i_word         d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output rv32i_word         mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  arb_state_t state;
  grant_t     last_grant;

  logic   grant_valid;
  grant_t grant_side;

  // Tie-break: with FAIR the side not served last wins; otherwise D wins.
  always_comb begin
    grant_valid = i_read | d_read | d_write;
    grant_side  = GRANT_D;
    if (i_read && (d_read || d_write)) begin
      grant_side = (FAIR && (last_grant == GRANT_D)) ? GRANT_I : GRANT_D;
    end else if (i_read) begin
      grant_side = GRANT_I;
    end
  end

  // mem_read/mem_write/mem_address/mem_wdata are the request register bank:
  // loaded on the grant edge and frozen until the L2 answers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= GRANT_D;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            if (grant_side == GRANT_I) begin
              state       <= SERVE_I;
              mem_read    <= 1'b1;
              mem_write   <= 1'b0;
              mem_address <= line_align(i_address);
            end else begin
              // A simultaneous d_read/d_write is illegal; the write wins.
              state       <= SERVE_D;
              mem_read    <= ~d_write;
              mem_write   <= d_write;
              mem_address <= line_align(d_address);
              mem_wdata   <= d_wdata;
            end
          end
        end
        SERVE_I, SERVE_D: begin
          if (mem_resp) begin
            state      <= RELEASE;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            last_grant <= (state == SERVE_I) ? GRANT_I : GRANT_D;
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Completion is steered combinationally so the L1 sees it with zero added
  // latency. Gated by rst so a response racing a reset is dropped.
  assign i_resp  = ~rst & mem_resp & (state == SERVE_I);
  assign d_resp  = ~rst & mem_resp & (state == SERVE_D);
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  a_d_rw_exclusive : assert property (@(posedge clk) disable iff (rst)
    !(d_read && d_write));

  a_mem_rw_exclusive : assert property (@(posedge clk) disable iff (rst)
    !(mem_read && mem_write));

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter. Two instances share all inputs: dut (FAIR=1)
// and dut_fp (FAIR=0); each phase checks the instance it targets.
module tb_l2_arbiter;
  import rv32i_types::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_read, d_read, d_write, mem_resp;
  rv32i_word         i_address, d_address;
  logic [LINE_W-1:0] d_wdata, mem_rdata;

  logic [LINE_W-1:0] i_rdata, d_rdata, mem_wdata;
  logic              i_resp, d_resp, mem_read, mem_write;
  rv32i_word         mem_address;

  logic [LINE_W-1:0] fp_i_rdata, fp_d_rdata, fp_mem_wdata;
  logic              fp_i_resp, fp_d_resp, fp_mem_read, fp_mem_write;
  rv32i_word         fp_mem_address;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [LINE_W-1:0] LINE_AA = {8{32'hAAAA_AAAA}};
  localparam logic [LINE_W-1:0] LINE_55 = {8{32'h5555_5555}};
  localparam logic [LINE_W-1:0] LINE_FF = {8{32'hFFFF_FFFF}};
  localparam logic [LINE_W-1:0] LINE_C3 = {8{32'hC3C3_C3C3}};

  always #5 clk = ~clk;

  l2_arbiter #(.FAIR(1'b1)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  l2_arbiter #(.FAIR(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(fp_i_rdata), .i_resp(fp_i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(fp_d_rdata), .d_resp(fp_d_resp),
    .mem_read(fp_mem_read), .mem_write(fp_mem_write), .mem_address(fp_mem_address),
    .mem_wdata(fp_mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  task automatic check(input string tag, input logic [LINE_W-1:0] got,
                       input logic [LINE_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    i_read    = 1'b0;
    d_read    = 1'b0;
    d_write   = 1'b0;
    mem_resp  = 1'b0;
    i_address = '0;
    d_address = '0;
    d_wdata   = '0;
    mem_rdata = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    // ---- reset values ----
    do_reset();
    check("rst_mem_read",  mem_read,    1'b0);
    check("rst_mem_write", mem_write,   1'b0);
    check("rst_mem_addr",  mem_address, 32'h0);
    check("rst_mem_wdata", mem_wdata,   '0);
    check("rst_i_resp",    i_resp,      1'b0);
    check("rst_d_resp",    d_resp,      1'b0);
    check("rst_state",     dut.state,   IDLE);

    // ---- round-robin ties out of reset: I, then D, then I ----
    i_read = 1'b1; i_address = 32'h0000_1234;
    d_read = 1'b1; d_address = 32'h0000_2048;
    tick();
    check("rr_tie1_read",  mem_read,    1'b1);
    check("rr_tie1_write", mem_write,   1'b0);
    check("rr_tie1_addr",  mem_address, 32'h0000_1220);
    i_address = 32'h0000_9990;
    tick();
    check("rr_hold_addr",  mem_address, 32'h0000_1220);
    check("rr_hold_read",  mem_read,    1'b1);
    mem_resp = 1'b1; mem_rdata = LINE_AA;
    #1;
    check("rr_tie1_i_resp", i_resp, 1'b1);
    check("rr_tie1_d_resp", d_resp, 1'b0);
    tick();
    mem_resp = 1'b0; i_read = 1'b0;
    #1;
    check("rr_release_read", mem_read,  1'b0);
    check("rr_release_st",   dut.state, RELEASE);
    tick();
    check("rr_idle_read", mem_read, 1'b0);
    i_read = 1'b1; i_address = 32'h0000_3000;
    tick();
    check("rr_tie2_addr",  mem_address, 32'h0000_2040);
    check("rr_tie2_read",  mem_read,    1'b1);
    mem_resp = 1'b1; mem_rdata = LINE_C3;
    #1;
    check("rr_tie2_d_resp", d_resp,  1'b1);
    check("rr_tie2_i_resp", i_resp,  1'b0);
    check("rr_tie2_d_rdata", d_rdata, LINE_C3);
    tick();
    mem_resp = 1'b0; d_read = 1'b0;
    tick();
    d_read = 1'b1; d_address = 32'h0000_4000;
    tick();
    check("rr_tie3_addr", mem_address, 32'h0000_3000);

    // ---- single I miss ----
    do_reset();
    i_read = 1'b1; i_address = 32'h0000_1234;
    tick();
    check("imiss_read",  mem_read,    1'b1);
    check("imiss_write", mem_write,   1'b0);
    check("imiss_addr",  mem_address, 32'h0000_1220);
    mem_resp = 1'b1; mem_rdata = LINE_AA;
    #1;
    check("imiss_i_resp",  i_resp,  1'b1);
    check("imiss_i_rdata", i_rdata, LINE_AA);
    check("imiss_d_resp",  d_resp,  1'b0);
    check("imiss_d_rdata", d_rdata, LINE_AA);
    tick();
    mem_resp = 1'b0; i_read = 1'b0;
    tick();
    tick();

    // ---- D write-back ----
    d_write = 1'b1; d_address = 32'h8000_0040; d_wdata = LINE_55;
    tick();
    check("wb_write", mem_write,   1'b1);
    check("wb_read",  mem_read,    1'b0);
    check("wb_addr",  mem_address, 32'h8000_0040);
    check("wb_wdata", mem_wdata,   LINE_55);
    d_wdata = LINE_FF; d_address = 32'h1234_5678;
    tick();
    check("wb_hold_wdata", mem_wdata,   LINE_55);
    check("wb_hold_addr",  mem_address, 32'h8000_0040);
    check("wb_hold_write", mem_write,   1'b1);
    mem_resp = 1'b1;
    #1;
    check("wb_d_resp", d_resp, 1'b1);
    check("wb_i_resp", i_resp, 1'b0);
    tick();
    d_write = 1'b0;
    #1;
    // ---- late response in RELEASE, then spurious response in IDLE ----
    check("late_state",  dut.state, RELEASE);
    check("late_d_resp", d_resp,    1'b0);
    check("late_i_resp", i_resp,    1'b0);
    check("late_write",  mem_write, 1'b0);
    tick();
    check("late_next_state", dut.state, IDLE);
    #1;
    check("spur_d_resp", d_resp, 1'b0);
    check("spur_i_resp", i_resp, 1'b0);
    tick();
    mem_resp = 1'b0;
    check("spur_state", dut.state, IDLE);
    check("spur_read",  mem_read,  1'b0);

    // ---- reset mid-service ----
    d_read = 1'b1; d_address = 32'h0000_0100;
    tick();
    check("rmid_read", mem_read, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; d_read = 1'b0;
    #1;
    check("rmid_read0",  mem_read,    1'b0);
    check("rmid_write0", mem_write,   1'b0);
    check("rmid_addr0",  mem_address, 32'h0);
    check("rmid_state",  dut.state,   IDLE);
    mem_resp = 1'b1;
    #1;
    check("rmid_no_d_resp", d_resp, 1'b0);
    tick();
    mem_resp = 1'b0;
    check("rmid_state2", dut.state, IDLE);

    // ---- fixed priority: three ties all go to D, then I ----
    do_reset();
    i_read = 1'b1; i_address = 32'h0000_1000;
    d_read = 1'b1; d_address = 32'h0000_2000;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("fp_tie_addr", fp_mem_address, 32'h0000_2000 + 32'(k) * 32'h100);
      check("fp_tie_read", fp_mem_read, 1'b1);
      mem_resp = 1'b1;
      #1;
      check("fp_tie_d_resp", fp_d_resp, 1'b1);
      check("fp_tie_i_resp", fp_i_resp, 1'b0);
      tick();
      mem_resp = 1'b0; d_read = 1'b0;
      tick();
      if (k < 2) begin
        d_read = 1'b1; d_address = 32'h0000_2000 + 32'(k + 1) * 32'h100;
      end
    end
    tick();
    check("fp_i_addr", fp_mem_address, 32'h0000_1000);
    check("fp_i_read", fp_mem_read,    1'b1);
    mem_resp = 1'b1;
    #1;
    check("fp_i_resp", fp_i_resp, 1'b1);
    tick();
    mem_resp = 1'b0; i_read = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
